// File: rtl/ram_port_arbiter.sv
// N-host req/gnt/rvalid arbiter (fixed or round-robin) in front of a single-port SRAM with window checking.
// Latency: grant is combinational; host_rvalid_o follows exactly MemLatency cycles after the grant.
// Backpressure: none; host_gnt_o is the only stall and one access is accepted per cycle. Define RAM_ARB_PERF_CNT_EN for grant counters.
module ram_port_arbiter #(
    parameter int unsigned          NrPorts    = 2,
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          MemLatency = 1,
    parameter bit                   RoundRobin = 1'b1,
    parameter logic [AddrWidth-1:0] MemBase    = AddrWidth'(32'h00100000),
    parameter logic [AddrWidth-1:0] MemSize    = AddrWidth'(32'h00100000)
) (
    input  logic                                  clk_sys,
    input  logic                                  rst_sys_n,
    input  logic [NrPorts-1:0]                    host_req_i,
    input  logic [NrPorts-1:0]                    host_we_i,
    input  logic [NrPorts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NrPorts-1:0][AddrWidth-1:0]     host_addr_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrPorts-1:0]                    host_gnt_o,
    output logic [NrPorts-1:0]                    host_rvalid_o,
    output logic                                  host_err_o,
    output logic [DataWidth-1:0]                  host_rdata_o,
    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [DataWidth/8-1:0]                mem_be_o,
    output logic [AddrWidth-1:0]                  mem_addr_o,
    output logic [DataWidth-1:0]                  mem_wdata_o,
    input  logic [DataWidth-1:0]                  mem_rdata_i,
    output logic [NrPorts-1:0][31:0]              grant_cnt_o
);

    localparam int unsigned IdxW      = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int unsigned LastStage = MemLatency - 1;
    // One extra bit so the window end can be represented without wrapping.
    localparam logic [AddrWidth:0] WinLo   = {1'b0, MemBase};
    localparam logic [AddrWidth:0] WinEnd  = {1'b0, MemBase} + {1'b0, MemSize};
    localparam logic [AddrWidth:0] AddrTop = {1'b1, {AddrWidth{1'b0}}};

    if (NrPorts < 2 || NrPorts > 8) begin : g_bad_ports
        $error("ram_port_arbiter: NrPorts must be 2..8");
    end
    if (MemLatency < 1 || MemLatency > 4) begin : g_bad_latency
        $error("ram_port_arbiter: MemLatency must be 1..4");
    end
    if (WinEnd > AddrTop) begin : g_bad_window
        $error("ram_port_arbiter: MemBase+MemSize overflows the address space");
    end
    if (MemSize == '0 || (MemSize & (MemSize - 1'b1)) != '0) begin : g_bad_size
        $error("ram_port_arbiter: MemSize must be a power of two");
    end

    logic [IdxW-1:0]            rr_ptr_q;
    logic [IdxW-1:0]            rr_ptr_d;
    logic                       gnt_vld;
    logic [IdxW-1:0]            gnt_idx;
    logic [AddrWidth-1:0]       win_addr;
    logic                       in_win;
    logic [MemLatency-1:0]      rsp_vld_q;
    logic [MemLatency-1:0]      rsp_err_q;
    logic [MemLatency-1:0][IdxW-1:0] rsp_idx_q;

    // Pick the winner: scan from the RR pointer (or from port 0 in fixed mode), first requester wins.
    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cand_idx;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NrPorts; off++) begin
            cand = RoundRobin ? (32'(rr_ptr_q) + off) : off;
            if (cand >= NrPorts) begin
                cand = cand - NrPorts;
            end
            cand_idx = IdxW'(cand);
            if (!gnt_vld && host_req_i[cand_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (32'(gnt_idx) == NrPorts - 1) ? '0 : gnt_idx + IdxW'(1);
        end
    end

    // Forward only the winner's fields; out-of-window or idle cycles leave the memory bus at zero.
    always_comb begin
        win_addr = host_addr_i[gnt_idx];
        in_win   = ({1'b0, win_addr} >= WinLo) && ({1'b0, win_addr} < WinEnd);
        for (int unsigned i = 0; i < NrPorts; i++) begin
            host_gnt_o[i] = gnt_vld && (gnt_idx == IdxW'(i));
        end
        mem_req_o   = gnt_vld && in_win;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_we_o    = host_we_i[gnt_idx];
            mem_be_o    = host_be_i[gnt_idx];
            mem_addr_o  = win_addr - MemBase;
            mem_wdata_o = host_wdata_i[gnt_idx];
        end
    end

    // Round-robin pointer moves past the last winner and holds on idle cycles.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Response tracker: one {valid, port, err} slot per cycle of memory latency, so order matches grant order.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rsp_vld_q <= '0;
            rsp_err_q <= '0;
            rsp_idx_q <= '0;
        end else begin
            for (int unsigned s = LastStage; s > 0; s--) begin
                rsp_vld_q[s] <= rsp_vld_q[s-1];
                rsp_err_q[s] <= rsp_err_q[s-1];
                rsp_idx_q[s] <= rsp_idx_q[s-1];
            end
            rsp_vld_q[0] <= gnt_vld;
            rsp_err_q[0] <= gnt_vld && !in_win;
            rsp_idx_q[0] <= gnt_idx;
        end
    end

    // Steer the oldest slot back to its host; errored accesses return zero data.
    always_comb begin
        for (int unsigned i = 0; i < NrPorts; i++) begin
            host_rvalid_o[i] = rsp_vld_q[LastStage] && (rsp_idx_q[LastStage] == IdxW'(i));
        end
        host_err_o   = rsp_vld_q[LastStage] && rsp_err_q[LastStage];
        host_rdata_o = (rsp_vld_q[LastStage] && !rsp_err_q[LastStage]) ? mem_rdata_i : '0;
    end

`ifdef RAM_ARB_PERF_CNT_EN
    logic [NrPorts-1:0][31:0] grant_cnt_q;

    // Free-running per-port grant counters, wrapping naturally at 2^32.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            grant_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NrPorts; i++) begin
                if (host_gnt_o[i]) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end
    assign grant_cnt_o = grant_cnt_q;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: two arbiter instances (3-port RR, latency 3; 2-port fixed, latency 1) with behavioural SRAMs.
// Responses are predicted into per-instance queues at grant time and matched as rvalid appears.
// Stimulus is driven #1 after the rising edge; everything is sampled on the falling edge.
module tb_ram_port_arbiter;

    typedef struct {
        int          port;
        bit          err;
        bit          chk;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    logic mem_fill  = 1'b1;
    int   cyc       = 0;
    int   tests     = 0;
    int   fails     = 0;

    rsp_t        q_a[$];
    rsp_t        q_b[$];
    logic [31:0] ref_a [256];
    logic [31:0] ref_b [256];
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] a_pipe [3];
    logic [31:0] b_pipe;

    // Instance A: 3 ports, round robin, latency 3
    logic [2:0]        a_req, a_we, a_gnt, a_rvalid;
    logic [2:0][3:0]   a_be;
    logic [2:0][31:0]  a_addr, a_wdata, a_cnt;
    logic              a_err, a_mreq, a_mwe;
    logic [31:0]       a_rdata, a_maddr, a_mwdata, a_mrdata;
    logic [3:0]        a_mbe;

    // Instance B: 2 ports, fixed priority, latency 1
    logic [1:0]        b_req, b_we, b_gnt, b_rvalid;
    logic [1:0][3:0]   b_be;
    logic [1:0][31:0]  b_addr, b_wdata, b_cnt;
    logic              b_err, b_mreq, b_mwe;
    logic [31:0]       b_rdata, b_maddr, b_mwdata, b_mrdata;
    logic [3:0]        b_mbe;

    ram_port_arbiter #(.NrPorts(3), .MemLatency(3), .RoundRobin(1'b1)) dut_a (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .host_req_i(a_req), .host_we_i(a_we), .host_be_i(a_be), .host_addr_i(a_addr),
        .host_wdata_i(a_wdata), .host_gnt_o(a_gnt), .host_rvalid_o(a_rvalid),
        .host_err_o(a_err), .host_rdata_o(a_rdata), .mem_req_o(a_mreq), .mem_we_o(a_mwe),
        .mem_be_o(a_mbe), .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata),
        .mem_rdata_i(a_mrdata), .grant_cnt_o(a_cnt)
    );

    ram_port_arbiter #(.NrPorts(2), .MemLatency(1), .RoundRobin(1'b0)) dut_b (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .host_req_i(b_req), .host_we_i(b_we), .host_be_i(b_be), .host_addr_i(b_addr),
        .host_wdata_i(b_wdata), .host_gnt_o(b_gnt), .host_rvalid_o(b_rvalid),
        .host_err_o(b_err), .host_rdata_o(b_rdata), .mem_req_o(b_mreq), .mem_we_o(b_mwe),
        .mem_be_o(b_mbe), .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata),
        .mem_rdata_i(b_mrdata), .grant_cnt_o(b_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Behavioural SRAM for A: byte-enable writes, read data MemLatency=3 cycles after the request.
    always @(posedge clk_sys) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA500_0000 | 32'(i);
        end else if (a_mreq && a_mwe) begin
            for (int b = 0; b < 4; b++)
                if (a_mbe[b]) mem_a[a_maddr[9:2]][8*b +: 8] <= a_mwdata[8*b +: 8];
        end
        a_pipe[0] <= a_mreq ? mem_a[a_maddr[9:2]] : 32'h0BAD_0BAD;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
    end
    assign a_mrdata = a_pipe[2];

    // Behavioural read-only SRAM for B, latency 1.
    always @(posedge clk_sys) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 32'h5B00_0000 | 32'(i);
        end
        b_pipe <= b_mreq ? mem_b[b_maddr[9:2]] : 32'h0BAD_0BAD;
    end
    assign b_mrdata = b_pipe;

    // Scoreboard for A: every rvalid must match the oldest predicted response, on its due cycle.
    always @(negedge clk_sys) begin
        rsp_t e;
        logic [2:0] exp_v;
        if (a_rvalid !== 3'b000) begin
            tests++;
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL a_rsp_unexpected: rvalid=%b at cyc %0d, required none", a_rvalid, cyc);
            end else begin
                e = q_a.pop_front();
                exp_v = 3'(1) << e.port;
                if (a_rvalid !== exp_v || a_err !== e.err || (e.chk && a_rdata !== e.data) || cyc != e.due) begin
                    fails++;
                    $display("FAIL a_rsp: rvalid=%b err=%b rdata=%h cyc=%0d, required rvalid=%b err=%b rdata=%h cyc=%0d",
                             a_rvalid, a_err, a_rdata, cyc, exp_v, e.err, e.data, e.due);
                end
            end
        end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            tests++;
            fails++;
            $display("FAIL a_rsp_missing: no rvalid at cyc %0d, required port %0d", cyc, e.port);
        end
    end

    // Scoreboard for B.
    always @(negedge clk_sys) begin
        rsp_t e;
        logic [1:0] exp_v;
        if (b_rvalid !== 2'b00) begin
            tests++;
            if (q_b.size() == 0) begin
                fails++;
                $display("FAIL b_rsp_unexpected: rvalid=%b at cyc %0d, required none", b_rvalid, cyc);
            end else begin
                e = q_b.pop_front();
                exp_v = 2'(1) << e.port;
                if (b_rvalid !== exp_v || b_err !== e.err || (e.chk && b_rdata !== e.data) || cyc != e.due) begin
                    fails++;
                    $display("FAIL b_rsp: rvalid=%b err=%b rdata=%h cyc=%0d, required rvalid=%b err=%b rdata=%h cyc=%0d",
                             b_rvalid, b_err, b_rdata, cyc, exp_v, e.err, e.data, e.due);
                end
            end
        end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
            e = q_b.pop_front();
            tests++;
            fails++;
            $display("FAIL b_rsp_missing: no rvalid at cyc %0d, required port %0d", cyc, e.port);
        end
    end

    task automatic push_a(input int port, input bit err, input bit chk, input logic [31:0] data);
        rsp_t e;
        e.port = port; e.err = err; e.chk = chk; e.data = data; e.due = cyc + 3;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int port, input bit err, input bit chk, input logic [31:0] data);
        rsp_t e;
        e.port = port; e.err = err; e.chk = chk; e.data = data; e.due = cyc + 1;
        q_b.push_back(e);
    endtask

    task automatic clr_inputs();
        a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys); #1;
            clr_inputs();
        end
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        clr_inputs();
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b0 || a_rvalid !== 3'b0 || a_err !== 1'b0 || a_rdata !== 32'h0 || a_mreq !== 1'b0 ||
            a_mwe !== 1'b0 || a_mbe !== 4'h0 || a_maddr !== 32'h0 || a_mwdata !== 32'h0 || a_cnt !== '0) begin
            fails++;
            $display("FAIL reset_a: gnt=%b rvalid=%b err=%b rdata=%h mreq=%b maddr=%h cnt=%h, required all zero",
                     a_gnt, a_rvalid, a_err, a_rdata, a_mreq, a_maddr, a_cnt);
        end
        tests++;
        if (b_gnt !== 2'b0 || b_rvalid !== 2'b0 || b_err !== 1'b0 || b_rdata !== 32'h0 || b_mreq !== 1'b0 ||
            b_maddr !== 32'h0 || b_cnt !== '0) begin
            fails++;
            $display("FAIL reset_b: gnt=%b rvalid=%b err=%b rdata=%h mreq=%b maddr=%h, required all zero",
                     b_gnt, b_rvalid, b_err, b_rdata, b_mreq, b_maddr);
        end
        @(posedge clk_sys); #1;
        mem_fill  = 1'b0;
        rst_sys_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk_sys); #1;
        b_req = 2'b10; b_addr[1] = 32'h0010_0010; b_be[1] = 4'hF;
        @(negedge clk_sys);
        tests++;
        if (b_gnt !== 2'b10 || b_mreq !== 1'b1 || b_maddr !== 32'h10 || b_mwe !== 1'b0) begin
            fails++;
            $display("FAIL single_read_gnt: gnt=%b mreq=%b maddr=%h we=%b, required 10 1 00000010 0",
                     b_gnt, b_mreq, b_maddr, b_mwe);
        end
        push_b(1, 1'b0, 1'b1, ref_b[4]);
        @(posedge clk_sys); #1;
        clr_inputs();
        @(negedge clk_sys);
        tests++;
        if (b_rvalid !== 2'b10 || b_err !== 1'b0 || b_rdata !== ref_b[4]) begin
            fails++;
            $display("FAIL single_read_rsp: rvalid=%b err=%b rdata=%h, required 10 0 %h",
                     b_rvalid, b_err, b_rdata, ref_b[4]);
        end
        idle(2);
    endtask

    task automatic test_fixed_priority();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_sys); #1;
            b_req = 2'b11;
            b_addr[0] = 32'h0010_0000 + 32'(8 * i);
            b_addr[1] = 32'h0010_0100;
            @(negedge clk_sys);
            tests++;
            if (b_gnt !== 2'b01) begin
                fails++;
                $display("FAIL fixed_prio_%0d: gnt=%b, required 01", i, b_gnt);
            end
            push_b(0, 1'b0, 1'b1, ref_b[2 * i]);
        end
        @(posedge clk_sys); #1;
        b_req = 2'b10;
        @(negedge clk_sys);
        tests++;
        if (b_gnt !== 2'b10 || b_maddr !== 32'h100) begin
            fails++;
            $display("FAIL fixed_prio_release: gnt=%b maddr=%h, required 10 00000100", b_gnt, b_maddr);
        end
        push_b(1, 1'b0, 1'b1, ref_b[64]);
        idle(3);
    endtask

    task automatic test_round_robin();
        int exp_p;
        logic [2:0] exp_g;
        for (int k = 0; k < 3; k++) a_addr[k] = 32'h0010_0000 + 32'(32 * k);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_sys); #1;
            a_req = 3'b111;
            @(negedge clk_sys);
            exp_p = i % 3;
            exp_g = 3'(1) << exp_p;
            tests++;
            if (a_gnt !== exp_g || a_mreq !== 1'b1 || a_maddr !== 32'(32 * exp_p)) begin
                fails++;
                $display("FAIL rr_order_%0d: gnt=%b maddr=%h, required %b %h", i, a_gnt, a_maddr, exp_g, 32'(32 * exp_p));
            end
            push_a(exp_p, 1'b0, 1'b1, ref_a[8 * exp_p]);
        end
        @(posedge clk_sys); #1;
        a_req = 3'b000;
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b000 || a_mreq !== 1'b0 || a_maddr !== 32'h0) begin
            fails++;
            $display("FAIL rr_idle: gnt=%b mreq=%b maddr=%h, required 000 0 0", a_gnt, a_mreq, a_maddr);
        end
        @(posedge clk_sys); #1;
        a_req = 3'b111;
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b010) begin
            fails++;
            $display("FAIL rr_ptr_hold: gnt=%b, required 010", a_gnt);
        end
        push_a(1, 1'b0, 1'b1, ref_a[8]);
        idle(5);
    endtask

    task automatic test_back_to_back();
        int t0;
        @(posedge clk_sys); #1;
        a_req = 3'b001; a_we[0] = 1'b1; a_be[0] = 4'hF;
        a_addr[0] = 32'h0010_0040; a_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk_sys);
        t0 = cyc;
        tests++;
        if (a_gnt !== 3'b001 || a_mreq !== 1'b1 || a_mwe !== 1'b1 || a_mbe !== 4'hF ||
            a_maddr !== 32'h40 || a_mwdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL b2b_write: gnt=%b mreq=%b we=%b be=%h maddr=%h wdata=%h, required 001 1 1 f 00000040 deadbeef",
                     a_gnt, a_mreq, a_mwe, a_mbe, a_maddr, a_mwdata);
        end
        ref_a[16] = 32'hDEAD_BEEF;
        push_a(0, 1'b0, 1'b0, 32'h0);
        @(posedge clk_sys); #1;
        clr_inputs();
        a_req = 3'b010; a_addr[1] = 32'h0010_0040; a_be[1] = 4'hF;
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b010 || a_mreq !== 1'b1 || a_mwe !== 1'b0 || a_mwdata !== 32'h0) begin
            fails++;
            $display("FAIL b2b_read: gnt=%b mreq=%b we=%b wdata=%h, required 010 1 0 0", a_gnt, a_mreq, a_mwe, a_mwdata);
        end
        push_a(1, 1'b0, 1'b1, ref_a[16]);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_sys); #1;
            clr_inputs();
            @(negedge clk_sys);
            if (cyc == t0 + 3) begin
                tests++;
                if (a_rvalid !== 3'b001) begin
                    fails++;
                    $display("FAIL b2b_rsp_write: rvalid=%b at t+3, required 001", a_rvalid);
                end
            end
            if (cyc == t0 + 4) begin
                tests++;
                if (a_rvalid !== 3'b010 || a_rdata !== 32'hDEAD_BEEF) begin
                    fails++;
                    $display("FAIL b2b_rsp_read: rvalid=%b rdata=%h at t+4, required 010 deadbeef", a_rvalid, a_rdata);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_error();
        @(posedge clk_sys); #1;
        a_req = 3'b100; a_we[2] = 1'b1; a_be[2] = 4'hF;
        a_addr[2] = 32'h0020_0000; a_wdata[2] = 32'h1234_5678;
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b100 || a_mreq !== 1'b0 || a_mwe !== 1'b0) begin
            fails++;
            $display("FAIL err_above: gnt=%b mreq=%b we=%b, required 100 0 0", a_gnt, a_mreq, a_mwe);
        end
        push_a(2, 1'b1, 1'b1, 32'h0);
        @(posedge clk_sys); #1;
        clr_inputs();
        a_req = 3'b001; a_addr[0] = 32'h000F_FFFC;
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b001 || a_mreq !== 1'b0) begin
            fails++;
            $display("FAIL err_below: gnt=%b mreq=%b, required 001 0", a_gnt, a_mreq);
        end
        push_a(0, 1'b1, 1'b1, 32'h0);
        @(posedge clk_sys); #1;
        clr_inputs();
        a_req = 3'b010; a_addr[1] = 32'h001F_FFFC;
        @(negedge clk_sys);
        tests++;
        if (a_gnt !== 3'b010 || a_mreq !== 1'b1 || a_maddr !== 32'h000F_FFFC) begin
            fails++;
            $display("FAIL win_top: gnt=%b mreq=%b maddr=%h, required 010 1 000ffffc", a_gnt, a_mreq, a_maddr);
        end
        push_a(1, 1'b0, 1'b1, ref_a[255]);
        idle(5);
        tests++;
        if (mem_a[0] !== ref_a[0]) begin
            fails++;
            $display("FAIL err_no_write: sram[0]=%h, required %h", mem_a[0], ref_a[0]);
        end
    endtask

    task automatic test_reset_flush();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_sys); #1;
            clr_inputs();
            a_req = 3'(1) << k;
            a_addr[k] = 32'h0010_0000 + 32'(4 * k);
            @(negedge clk_sys);
            push_a(k, 1'b0, 1'b1, ref_a[k]);
        end
        @(posedge clk_sys); #1;
        clr_inputs();
        #2;
        rst_sys_n = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (2) @(posedge clk_sys);
        #1;
        rst_sys_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            tests++;
            if (a_rvalid !== 3'b000 || a_err !== 1'b0) begin
                fails++;
                $display("FAIL flush_%0d: rvalid=%b err=%b after reset, required 000 0", k, a_rvalid, a_err);
            end
        end
    endtask

    task automatic test_perf();
        tests++;
        if (a_cnt !== '0) begin
            fails++;
            $display("FAIL perf_cleared: cnt=%h, required 0", a_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_sys); #1;
            clr_inputs();
            a_req = 3'b010; a_addr[1] = 32'h0010_0000 + 32'(4 * i);
            @(negedge clk_sys);
            push_a(1, 1'b0, 1'b1, ref_a[i]);
        end
        idle(4);
        tests++;
`ifdef RAM_ARB_PERF_CNT_EN
        if (a_cnt[1] !== 32'd5 || a_cnt[0] !== 32'd0 || a_cnt[2] !== 32'd0) begin
            fails++;
            $display("FAIL perf_count: cnt0=%0d cnt1=%0d cnt2=%0d, required 0 5 0", a_cnt[0], a_cnt[1], a_cnt[2]);
        end
`else
        if (a_cnt !== '0) begin
            fails++;
            $display("FAIL perf_tied: cnt=%h, required 0", a_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_a[i] = 32'hA500_0000 | 32'(i);
            ref_b[i] = 32'h5B00_0000 | 32'(i);
        end
        clr_inputs();
        test_reset();
        test_round_robin();
        test_single_read();
        test_fixed_priority();
        test_back_to_back();
        test_error();
        test_reset_flush();
        test_perf();
        idle(6);
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            fails++;
            $display("FAIL drain: pending a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
